// File: rtl/systolic_drain.sv
// Output-side collector for the systolic array: re-aligns column-skewed
// result rows, tags the last row of a tile and buffers aligned rows in a
// FIFO behind a valid/ready handshake.
module systolic_drain #(
    parameter int COLS       = 4,
    parameter int PW         = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [CNT_W-1:0]          rows_per_tile,
    input  logic                      col_valid,
    input  logic [COLS-1:0][PW-1:0]   of_data,
    output logic                      o_valid,
    input  logic                      o_ready,
    output logic [COLS-1:0][PW-1:0]   o_data,
    output logic                      o_last,
    output logic                      busy,
    output logic                      done,
    output logic                      overflow
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int TAPS = COLS - 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [AW:0]      PTR_ONE = (AW + 1)'(1);

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

    state_t                    state, state_nxt;
    logic [CNT_W-1:0]          cnt, n_rows;
    logic                      accept, row_last;
    logic [TAPS-1:0]           vld_p, last_p;
    logic [COLS-1:0][PW-1:0]   row_p;

    logic [AW:0]               wr_ptr, rd_ptr;
    logic [COLS-1:0][PW-1:0]   mem_data [FIFO_DEPTH];
    logic                      mem_last [FIFO_DEPTH];
    logic                      fifo_empty, fifo_full;
    logic                      push_req, push, pop, drop;

    assign accept   = (state == ACTIVE) && col_valid;
    assign row_last = (cnt == (n_rows - CNT_ONE));
    assign busy     = (state != IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic and the done pulse on leaving DRAIN
    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            IDLE:    if (start) state_nxt = ACTIVE;
            ACTIVE:  if (accept && row_last) state_nxt = DRAIN;
            DRAIN: begin
                if ((vld_p == '0) && fifo_empty) begin
                    state_nxt = IDLE;
                    done      = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Tile length capture (zero rows treated as one) and accepted-row count
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            n_rows <= '0;
        end else if ((state == IDLE) && start) begin
            cnt    <= '0;
            n_rows <= (rows_per_tile == '0) ? CNT_ONE : rows_per_tile;
        end else if (accept) begin
            cnt    <= cnt + CNT_ONE;
        end
    end

    // --- stage p0..p(COLS-2): valid/last tag follows the row across the skew
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p  <= '0;
            last_p <= '0;
        end else begin
            vld_p[0]  <= accept;
            last_p[0] <= accept && row_last;
            for (int k = 1; k < TAPS; k++) begin
                vld_p[k]  <= vld_p[k-1];
                last_p[k] <= last_p[k-1];
            end
        end
    end

    // Column j waits COLS-1-j cycles so all columns line up with the last one
    for (genvar j = 0; j < COLS; j++) begin : g_col
        if (j == COLS - 1) begin : g_direct
            assign row_p[j] = of_data[j];
        end else begin : g_dly
            logic signed [PW-1:0] line_p [COLS-1-j];
            // Free-running data delay line; validity is carried by vld_p
            always_ff @(posedge clk) begin
                line_p[0] <= of_data[j];
                for (int k = 1; k < COLS - 1 - j; k++) begin
                    line_p[k] <= line_p[k-1];
                end
            end
            assign row_p[j] = line_p[COLS-2-j];
        end
    end

    // --- FIFO: a full FIFO still accepts a push when a pop happens together
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push_req   = vld_p[TAPS-1];
    assign pop        = o_valid && o_ready;
    assign push       = push_req && (!fifo_full || pop);
    assign drop       = push_req && fifo_full && !pop;

    assign o_valid = !fifo_empty;
    assign o_data  = fifo_empty ? '0   : mem_data[rd_ptr[AW-1:0]];
    assign o_last  = fifo_empty ? 1'b0 : mem_last[rd_ptr[AW-1:0]];

    // FIFO read/write pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // FIFO storage; contents are only visible through the non-empty head
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr[AW-1:0]] <= row_p;
            mem_last[wr_ptr[AW-1:0]] <= last_p[TAPS-1];
        end
    end

    // Sticky drop flag, cleared when a new tile starts
    always_ff @(posedge clk) begin
        if (rst)                          overflow <= 1'b0;
        else if (drop)                    overflow <= 1'b1;
        else if ((state == IDLE) && start) overflow <= 1'b0;
    end
endmodule
